// File: rtl/halt_commit_monitor_pkg.sv
// Shared types and helpers for the commit/halt monitor.
package monitor_pkg;

  localparam int unsigned ORDER_W_DEF = 64;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOOP     = 2'd1,
    HALTED   = 2'd2,
    TIMEDOUT = 2'd3
  } mon_state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/halt_commit_monitor_if.sv
// Core-side bundle observed by the commit/halt monitor.
interface halt_commit_monitor_if import monitor_pkg::*; #(
  parameter int unsigned NUM_CH  = 1,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ORDER_W = ORDER_W_DEF
);
  logic                            stall;
  logic                            pc_valid;
  logic [XLEN-1:0]                 pc_curr;
  logic [XLEN-1:0]                 pc_next;
  logic [NUM_CH-1:0]               commit_valid;
  logic [NUM_CH-1:0][ORDER_W-1:0]  commit_order;
  logic [ORDER_W-1:0]              order_base;
  logic                            halt;
  logic [XLEN-1:0]                 halt_pc;
  logic                            timeout;

  modport master (
    output stall, pc_valid, pc_curr, pc_next, commit_valid,
    input  commit_order, order_base, halt, halt_pc, timeout
  );

  modport slave (
    input  stall, pc_valid, pc_curr, pc_next, commit_valid,
    output commit_order, order_base, halt, halt_pc, timeout
  );
endinterface

// File: rtl/halt_commit_monitor_prefix.sv
// Exclusive prefix popcount of the per-lane commit strobes, plus the total.
module commit_prefix_count import monitor_pkg::*; #(
  parameter  int unsigned NUM_CH = 1,
  localparam int unsigned CNT_W  = cnt_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0]            valid,
  output logic [NUM_CH-1:0][CNT_W-1:0] prefix,
  output logic [CNT_W-1:0]             total
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      prefix[i] = acc;
      acc       = acc + CNT_W'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/halt_commit_monitor.sv
// Assigns RVFI order numbers to committing lanes, detects the self-loop halt
// and raises a sticky watchdog flag when nothing commits for too long.
module halt_commit_monitor import monitor_pkg::*; #(
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ORDER_W     = ORDER_W_DEF,
  parameter int unsigned HALT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  halt_commit_monitor_if.slave mon
);

  localparam int unsigned CNT_W  = cnt_width(NUM_CH);
  localparam int unsigned LOOP_W = cnt_width(HALT_CYCLES);
  localparam int unsigned IDLE_W = cnt_width(TIMEOUT);

  mon_state_e                 state_q, state_d;
  logic [LOOP_W-1:0]          loop_q, loop_d;
  logic [IDLE_W-1:0]          idle_q, idle_d;
  logic [ORDER_W-1:0]         order_base_q, order_base_d;
  logic                       halt_q, halt_d;
  logic [XLEN-1:0]            halt_pc_q, halt_pc_d;
  logic                       timeout_q, timeout_d;

  logic [NUM_CH-1:0][CNT_W-1:0] prefix;
  logic [CNT_W-1:0]             total;
  logic                         halted;
  logic                         count_en;
  logic                         qual;
  logic                         wd_fire;
  logic                         halt_hit;

  commit_prefix_count #(
    .NUM_CH (NUM_CH)
  ) u_prefix (
    .valid  (mon.commit_valid),
    .prefix (prefix),
    .total  (total)
  );

  assign halted   = (state_q == HALTED);
  assign count_en = ~mon.stall & ~halted;
  assign qual     = mon.pc_valid & ~mon.stall & (mon.pc_next == mon.pc_curr);

  // Per-lane order is the running base plus the commits in lower lanes.
  always_comb begin
    mon.commit_order = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mon.commit_order[i] = order_base_q + ORDER_W'(prefix[i]);
    end
  end

  assign mon.order_base = order_base_q;
  assign mon.halt       = halt_q;
  assign mon.halt_pc    = halt_pc_q;
  assign mon.timeout    = timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      loop_q       <= '0;
      idle_q       <= '0;
      order_base_q <= '0;
      halt_q       <= 1'b0;
      halt_pc_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      loop_q       <= loop_d;
      idle_q       <= idle_d;
      order_base_q <= order_base_d;
      halt_q       <= halt_d;
      halt_pc_q    <= halt_pc_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next state: everything freezes once HALTED; TIMEDOUT still watches for the halt loop.
  always_comb begin
    state_d      = state_q;
    loop_d       = loop_q;
    idle_d       = idle_q;
    order_base_d = order_base_q;
    halt_d       = halt_q;
    halt_pc_d    = halt_pc_q;
    timeout_d    = timeout_q;
    wd_fire      = 1'b0;
    halt_hit     = 1'b0;

    if (!halted) begin
      if (count_en) begin
        order_base_d = order_base_q + ORDER_W'(total);
      end

      // A zero TIMEOUT disables the watchdog entirely.
      if (TIMEOUT != 0) begin
        if (count_en && (total != '0)) begin
          idle_d = '0;
        end else if (idle_q != IDLE_W'(TIMEOUT)) begin
          idle_d = idle_q + 1'b1;
        end
        wd_fire = (idle_d == IDLE_W'(TIMEOUT)) && (state_q != TIMEDOUT);
      end

      // Stalls hold the streak; any unstalled non-qualifying cycle breaks it.
      if (qual) begin
        loop_d = loop_q + 1'b1;
      end else if (!mon.stall) begin
        loop_d = '0;
      end
      halt_hit = qual && (loop_d == LOOP_W'(HALT_CYCLES));

      if (wd_fire) begin
        timeout_d = 1'b1;
      end

      if (halt_hit) begin
        state_d   = HALTED;
        halt_d    = 1'b1;
        halt_pc_d = mon.pc_curr;
      end else if (wd_fire || (state_q == TIMEDOUT)) begin
        state_d = TIMEDOUT;
      end else if (loop_d != '0) begin
        state_d = LOOP;
      end else begin
        state_d = RUN;
      end
    end
  end

endmodule

// File: tb/tb_halt_commit_monitor.sv
// Directed bench for halt_commit_monitor with a cycle-level reference model.
module tb_halt_commit_monitor;

  localparam int unsigned NCH = 4;
  localparam int unsigned XL  = 32;
  localparam int unsigned OW  = 4;
  localparam int unsigned HC  = 2;
  localparam int unsigned TO  = 16;
  localparam int          MOD = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  halt_commit_monitor_if #(.NUM_CH(NCH), .XLEN(XL), .ORDER_W(OW)) bus ();

  halt_commit_monitor #(
    .NUM_CH(NCH), .XLEN(XL), .ORDER_W(OW), .HALT_CYCLES(HC), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: base number, cycles since last counted commit, self-loop streak.
  int          m_base   = 0;
  int          m_idle   = 0;
  int          m_streak = 0;
  bit          m_halt   = 1'b0;
  bit          m_to     = 1'b0;
  logic [31:0] m_halt_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int popc(input logic [3:0] v, input int upto);
    int n = 0;
    for (int k = 0; k < upto; k++) n += int'(v[k]);
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_base = 0; m_idle = 0; m_streak = 0;
        m_halt = 1'b0; m_to = 1'b0; m_halt_pc = '0;
      end else if (!m_halt) begin
        int  n;
        bit  q;
        n = popc(bus.commit_valid, NCH);
        q = bus.pc_valid && !bus.stall && (bus.pc_next == bus.pc_curr);
        if (!bus.stall) m_base = (m_base + n) % MOD;
        if (!bus.stall && n > 0) m_idle = 0;
        else if (m_idle < TO) m_idle++;
        if (m_idle == TO) m_to = 1'b1;
        if (q) m_streak++;
        else if (!bus.stall) m_streak = 0;
        if (m_streak == HC) begin
          m_halt    = 1'b1;
          m_halt_pc = bus.pc_curr;
        end
      end
    end
  end

  // Every falling edge: registered outputs and the valid lanes' orders.
  initial begin
    forever begin
      @(negedge clk);
      check("order_base", 64'(bus.order_base), 64'(m_base));
      check("halt", 64'(bus.halt), 64'(m_halt));
      check("halt_pc", 64'(bus.halt_pc), 64'(m_halt_pc));
      check("timeout", 64'(bus.timeout), 64'(m_to));
      for (int i = 0; i < NCH; i++) begin
        if (bus.commit_valid[i]) begin
          check($sformatf("commit_order[%0d]", i), 64'(bus.commit_order[i]),
                64'((m_base + popc(bus.commit_valid, i)) % MOD));
        end
      end
    end
  end

  task automatic set_in(input logic st, input logic pv, input logic [31:0] pc,
                        input logic [31:0] pn, input logic [3:0] cv);
    bus.stall        = st;
    bus.pc_valid     = pv;
    bus.pc_curr      = pc;
    bus.pc_next      = pn;
    bus.commit_valid = cv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    tick();
    tick();
    check("rst_order_base", 64'(bus.order_base), 64'd0);
    check("rst_halt", 64'(bus.halt), 64'd0);
    check("rst_halt_pc", 64'(bus.halt_pc), 64'd0);
    check("rst_timeout", 64'(bus.timeout), 64'd0);
    rst = 1'b1;

    // Ordering with holes, base 10 -> 13, then wrap through 15 -> 0.
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b1111); tick(); tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b0011); tick();
    check("ord_base10", 64'(bus.order_base), 64'd10);
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b1011); #1;
    check("ord_lane0", 64'(bus.commit_order[0]), 64'd10);
    check("ord_lane1", 64'(bus.commit_order[1]), 64'd11);
    check("ord_lane3", 64'(bus.commit_order[3]), 64'd12);
    tick();
    check("ord_base13", 64'(bus.order_base), 64'd13);
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b0011); tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b0100); #1;
    check("wrap_lane2", 64'(bus.commit_order[2]), 64'd15);
    tick();
    check("wrap_base0", 64'(bus.order_base), 64'd0);
    set_in(1'b1, 1'b0, 32'h0, 32'h0, 4'b1111); tick();
    check("stall_no_count", 64'(bus.order_base), 64'd0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b1010); #1;
    check("hole_lane1", 64'(bus.commit_order[1]), 64'd0);
    check("hole_lane3", 64'(bus.commit_order[3]), 64'd1);
    tick();
    check("hole_base2", 64'(bus.order_base), 64'd2);

    // Two qualifying cycles halt; the commit on the halting edge counts.
    do_reset();
    set_in(1'b0, 1'b1, 32'h60, 32'h60, 4'b0000); tick();
    check("halt_after1", 64'(bus.halt), 64'd0);
    set_in(1'b0, 1'b1, 32'h60, 32'h60, 4'b0001); tick();
    check("halt_after2", 64'(bus.halt), 64'd1);
    check("halt_pc60", 64'(bus.halt_pc), 64'h60);
    check("halt_edge_commit", 64'(bus.order_base), 64'd1);
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b1111); tick();
    check("halted_ignores", 64'(bus.order_base), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_halt", 64'(bus.halt), 64'd0);
    check("async_base", 64'(bus.order_base), 64'd0);
    check("async_pc", 64'(bus.halt_pc), 64'd0);
    rst = 1'b1;
    tick();

    // Stalls hold the streak.
    do_reset();
    set_in(1'b0, 1'b1, 32'h80, 32'h80, 4'b0000); tick();
    set_in(1'b1, 1'b1, 32'h80, 32'h80, 4'b0000); tick();
    set_in(1'b1, 1'b0, 32'h80, 32'h80, 4'b0000); tick();
    set_in(1'b1, 1'b1, 32'h80, 32'h84, 4'b0000); tick();
    check("stall_hold_nohalt", 64'(bus.halt), 64'd0);
    set_in(1'b0, 1'b1, 32'h80, 32'h80, 4'b0000); tick();
    check("stall_hold_halt", 64'(bus.halt), 64'd1);
    check("stall_hold_pc", 64'(bus.halt_pc), 64'h80);

    // An unstalled non-loop cycle breaks the streak.
    do_reset();
    set_in(1'b0, 1'b1, 32'h80, 32'h80, 4'b0000); tick();
    set_in(1'b1, 1'b1, 32'h80, 32'h80, 4'b0000); tick(); tick(); tick();
    set_in(1'b0, 1'b1, 32'h80, 32'h84, 4'b0000); tick();
    set_in(1'b0, 1'b1, 32'h80, 32'h80, 4'b0000); tick();
    check("break_nohalt", 64'(bus.halt), 64'd0);
    tick();
    check("break_rehalt", 64'(bus.halt), 64'd1);

    // pc_valid low while unstalled also breaks it.
    do_reset();
    set_in(1'b0, 1'b1, 32'h88, 32'h88, 4'b0000); tick();
    set_in(1'b0, 1'b0, 32'h88, 32'h88, 4'b0000); tick();
    set_in(1'b0, 1'b1, 32'h88, 32'h88, 4'b0000); tick();
    check("pvalid_break", 64'(bus.halt), 64'd0);

    // Watchdog fires on the 16th idle edge; halting still works afterwards.
    do_reset();
    repeat (15) tick();
    check("wd_15", 64'(bus.timeout), 64'd0);
    tick();
    check("wd_16", 64'(bus.timeout), 64'd1);
    set_in(1'b0, 1'b1, 32'h90, 32'h90, 4'b0001); tick();
    check("to_count_base", 64'(bus.order_base), 64'd1);
    check("to_not_halt", 64'(bus.halt), 64'd0);
    tick();
    check("to_then_halt", 64'(bus.halt), 64'd1);
    check("to_then_halt_pc", 64'(bus.halt_pc), 64'h90);
    check("to_sticky", 64'(bus.timeout), 64'd1);

    // A commit on cycle 15 restarts the watchdog.
    do_reset();
    repeat (14) tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b0001); tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000); tick();
    check("wd_restart16", 64'(bus.timeout), 64'd0);
    repeat (14) tick();
    check("wd_restart30", 64'(bus.timeout), 64'd0);
    tick();
    check("wd_restart31", 64'(bus.timeout), 64'd1);

    // Stalled commits do not feed the watchdog.
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 32'h0, 4'b1111);
    repeat (16) tick();
    check("wd_stall", 64'(bus.timeout), 64'd1);
    check("wd_stall_base", 64'(bus.order_base), 64'd0);

    // Halt and timeout on the same edge.
    do_reset();
    repeat (14) tick();
    set_in(1'b0, 1'b1, 32'hA0, 32'hA0, 4'b0000); tick();
    check("same_edge_pre", 64'(bus.halt), 64'd0);
    tick();
    check("same_edge_halt", 64'(bus.halt), 64'd1);
    check("same_edge_to", 64'(bus.timeout), 64'd1);
    tick();

    // Patterned sweep checked by the model on every cycle.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pc;
      logic [31:0] pn;
      logic [3:0]  cv;
      pc = 32'h100 + 32'((i / 9) * 4);
      pn = ((i % 4 == 1) || (i % 4 == 2)) ? pc : pc + 32'd4;
      cv = ((i % 40) >= 20) ? 4'b0000 : 4'((i * 5 + 1) % 16);
      set_in(1'((i % 7) == 3), 1'((i % 3) != 0), pc, pn, cv);
      if ((i % 60) == 59) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
